// File: rtl/noc_credit_sink.sv
// Credit-flow-controlled flit sink: buffers incoming flits in a show-ahead FIFO,
// presents them on a valid/ready stream and returns one credit per flit drained.
module noc_credit_sink #(
    parameter int FLIT_WIDTH        = 64,
    parameter int DEST_WIDTH        = 6,
    parameter int FLIT_BUFFER_DEPTH = 8,
    localparam int CNT_WIDTH        = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
    input  logic                  clk_noc,
    input  logic                  rst_n,
    input  logic [FLIT_WIDTH-1:0] data_in,
    input  logic [DEST_WIDTH-1:0] dest_in,
    input  logic                  is_tail_in,
    input  logic                  send_in,
    output logic                  credit_out,
    output logic                  out_tvalid,
    input  logic                  out_tready,
    output logic [FLIT_WIDTH-1:0] out_tdata,
    output logic [DEST_WIDTH-1:0] out_tdest,
    output logic                  out_tlast,
    output logic [CNT_WIDTH-1:0]  occupancy,
    output logic                  overflow_err,
    output logic                  proto_err
);

    localparam int PTR_WIDTH   = $clog2(FLIT_BUFFER_DEPTH);
    localparam int ENTRY_WIDTH = FLIT_WIDTH + DEST_WIDTH + 1;
    localparam logic [PTR_WIDTH-1:0] LAST_PTR = PTR_WIDTH'(FLIT_BUFFER_DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(FLIT_BUFFER_DEPTH);

    typedef enum logic [0:0] {
        PKT_IDLE = 1'b0,
        PKT_IN   = 1'b1
    } pkt_state_t;

    logic [ENTRY_WIDTH-1:0] mem_r [FLIT_BUFFER_DEPTH];
    logic [PTR_WIDTH-1:0]   wr_ptr_r, rd_ptr_r, wr_ptr_s, rd_ptr_s;
    logic [CNT_WIDTH-1:0]   count_r, count_s;
    logic                   credit_r, overflow_r, proto_r;
    logic                   push_s, pop_s, drop_s, proto_set_s;
    logic [ENTRY_WIDTH-1:0] head_s;
    logic [FLIT_WIDTH-1:0]  head_data_s;
    logic [DEST_WIDTH-1:0]  head_dest_s, pkt_dest_r, pkt_dest_s;
    logic                   head_last_s;
    pkt_state_t             state_r, state_s;

    assign head_s = mem_r[rd_ptr_r];
    assign {head_data_s, head_dest_s, head_last_s} = head_s;

    // Handshake decode, pointer wrap and occupancy update
    always_comb begin
        pop_s    = (count_r != {CNT_WIDTH{1'b0}}) && out_tready;
        push_s   = send_in && ((count_r < FULL_CNT) || pop_s);
        drop_s   = send_in && !push_s;
        wr_ptr_s = wr_ptr_r;
        rd_ptr_s = rd_ptr_r;
        count_s  = count_r;
        if (push_s) begin
            wr_ptr_s = (wr_ptr_r == LAST_PTR) ? {PTR_WIDTH{1'b0}} : wr_ptr_r + PTR_WIDTH'(1);
        end else begin
            wr_ptr_s = wr_ptr_r;
        end
        if (pop_s) begin
            rd_ptr_s = (rd_ptr_r == LAST_PTR) ? {PTR_WIDTH{1'b0}} : rd_ptr_r + PTR_WIDTH'(1);
        end else begin
            rd_ptr_s = rd_ptr_r;
        end
        case ({push_s, pop_s})
            2'b10:   count_s = count_r + CNT_WIDTH'(1);
            2'b01:   count_s = count_r - CNT_WIDTH'(1);
            default: count_s = count_r;
        endcase
    end

    // Packet tracker next state: latch dest on first flit, flag dest changes
    always_comb begin
        state_s     = state_r;
        pkt_dest_s  = pkt_dest_r;
        proto_set_s = 1'b0;
        if (pop_s) begin
            case (state_r)
                PKT_IDLE: begin
                    if (!head_last_s) begin
                        state_s    = PKT_IN;
                        pkt_dest_s = head_dest_s;
                    end else begin
                        state_s = PKT_IDLE;
                    end
                end
                PKT_IN: begin
                    proto_set_s = (head_dest_s != pkt_dest_r);
                    if (head_last_s) begin
                        state_s = PKT_IDLE;
                    end else begin
                        state_s = PKT_IN;
                    end
                end
                default: state_s = PKT_IDLE;
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Control state, credit pulse and sticky error flags
    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r   <= {PTR_WIDTH{1'b0}};
            rd_ptr_r   <= {PTR_WIDTH{1'b0}};
            count_r    <= {CNT_WIDTH{1'b0}};
            credit_r   <= 1'b0;
            overflow_r <= 1'b0;
            proto_r    <= 1'b0;
            state_r    <= PKT_IDLE;
            pkt_dest_r <= {DEST_WIDTH{1'b0}};
        end else begin
            wr_ptr_r   <= wr_ptr_s;
            rd_ptr_r   <= rd_ptr_s;
            count_r    <= count_s;
            credit_r   <= pop_s;
            overflow_r <= overflow_r | drop_s;
            proto_r    <= proto_r | proto_set_s;
            state_r    <= state_s;
            pkt_dest_r <= pkt_dest_s;
        end
    end

    // Flit storage; contents are never observed while the FIFO is empty
    always_ff @(posedge clk_noc) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {data_in, dest_in, is_tail_in};
        end
    end

    assign out_tvalid   = (count_r != {CNT_WIDTH{1'b0}});
    assign out_tdata    = out_tvalid ? head_data_s : {FLIT_WIDTH{1'b0}};
    assign out_tdest    = out_tvalid ? head_dest_s : {DEST_WIDTH{1'b0}};
    assign out_tlast    = out_tvalid & head_last_s;
    assign occupancy    = count_r;
    assign credit_out   = credit_r;
    assign overflow_err = overflow_r;
    assign proto_err    = proto_r;

endmodule

// File: tb/tb_noc_credit_sink.sv
// Randomized and directed bench for noc_credit_sink against a queue-based model
// of the buffer, credit return and packet-consistency rules.
module tb_noc_credit_sink;

    localparam int FW = 64;
    localparam int DW = 6;
    localparam int DEPTH = 8;
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [FW-1:0] data;
        logic [DW-1:0] dest;
        logic          last;
    } flit_t;

    logic          clk_noc = 1'b0;
    logic          rst_n;
    logic [FW-1:0] data_in;
    logic [DW-1:0] dest_in;
    logic          is_tail_in;
    logic          send_in;
    logic          credit_out;
    logic          out_tvalid;
    logic          out_tready;
    logic [FW-1:0] out_tdata;
    logic [DW-1:0] out_tdest;
    logic          out_tlast;
    logic [CW-1:0] occupancy;
    logic          overflow_err;
    logic          proto_err;

    noc_credit_sink #(.FLIT_WIDTH(FW), .DEST_WIDTH(DW), .FLIT_BUFFER_DEPTH(DEPTH)) dut (
        .clk_noc(clk_noc), .rst_n(rst_n), .data_in(data_in), .dest_in(dest_in),
        .is_tail_in(is_tail_in), .send_in(send_in), .credit_out(credit_out),
        .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tdata(out_tdata),
        .out_tdest(out_tdest), .out_tlast(out_tlast), .occupancy(occupancy),
        .overflow_err(overflow_err), .proto_err(proto_err)
    );

    always #5 clk_noc = ~clk_noc;

    // model state
    flit_t         q[$];
    logic          m_credit, m_overflow, m_proto, m_in_pkt;
    logic [DW-1:0] m_pkt_dest;

    int            n_checks = 0;
    int            n_pass = 0;
    int            credits_seen;
    logic [FW-1:0] dut_out[$];
    logic [FW-1:0] sent[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_clear();
        q.delete();
        m_credit = 1'b0; m_overflow = 1'b0; m_proto = 1'b0;
        m_in_pkt = 1'b0; m_pkt_dest = '0;
    endtask

    task automatic model_update(input logic s, input flit_t f, input logic r);
        int    sz;
        logic  pop;
        flit_t h;
        sz  = q.size();
        pop = (sz != 0) && r;
        if (pop) begin
            h = q.pop_front();
            if (!m_in_pkt) begin
                if (!h.last) begin
                    m_in_pkt = 1'b1;
                    m_pkt_dest = h.dest;
                end
            end else begin
                if (h.dest != m_pkt_dest) m_proto = 1'b1;
                if (h.last) m_in_pkt = 1'b0;
            end
        end
        if (s && (sz < DEPTH || pop)) q.push_back(f);
        else if (s) m_overflow = 1'b1;
        m_credit = pop;
    endtask

    task automatic compare_all();
        check("tvalid", 64'(out_tvalid), 64'(q.size() != 0));
        check("occupancy", 64'(occupancy), 64'(q.size()));
        if (q.size() != 0) begin
            check("tdata", out_tdata, q[0].data);
            check("tdest", 64'(out_tdest), 64'(q[0].dest));
            check("tlast", 64'(out_tlast), 64'(q[0].last));
        end
        check("credit_out", 64'(credit_out), 64'(m_credit));
        check("overflow_err", 64'(overflow_err), 64'(m_overflow));
        check("proto_err", 64'(proto_err), 64'(m_proto));
    endtask

    // one clock cycle: drive at negedge, model at posedge, compare at next negedge
    task automatic step(input logic s, input logic [FW-1:0] d, input logic [DW-1:0] de,
                        input logic t, input logic r);
        flit_t f;
        f = '{data: d, dest: de, last: t};
        send_in = s; data_in = d; dest_in = de; is_tail_in = t; out_tready = r;
        if (out_tvalid && r) dut_out.push_back(out_tdata);
        @(posedge clk_noc);
        model_update(s, f, r);
        @(negedge clk_noc);
        if (credit_out) credits_seen++;
        compare_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        send_in = 1'b0; out_tready = 1'b0;
        model_clear();
        repeat (2) @(negedge clk_noc);
        compare_all();
        rst_n = 1'b1;
        credits_seen = 0;
        dut_out.delete();
        sent.delete();
    endtask

    initial begin
        int cyc;
        rst_n = 1'b0; send_in = 1'b0; out_tready = 1'b0;
        data_in = '0; dest_in = '0; is_tail_in = 1'b0;
        do_reset();
        check("reset_tvalid", 64'(out_tvalid), 64'd0);
        check("reset_occ", 64'(occupancy), 64'd0);

        // single flit round trip
        step(1'b1, 64'hA5, 6'h05, 1'b1, 1'b1);
        check("single_tvalid", 64'(out_tvalid), 64'd1);
        check("single_tdata", out_tdata, 64'hA5);
        check("single_credit_early", 64'(credit_out), 64'd0);
        step(1'b0, 64'h0, 6'h0, 1'b0, 1'b1);
        check("single_credit", 64'(credit_out), 64'd1);
        check("single_occ", 64'(occupancy), 64'd0);
        step(1'b0, 64'h0, 6'h0, 1'b0, 1'b1);
        check("single_credit_once", 64'(credit_out), 64'd0);

        // fill, overflow, drain in order
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1'b1, 64'(i), 6'h01, 1'b1, 1'b0);
        check("fill_occ", 64'(occupancy), 64'd8);
        check("fill_ovf", 64'(overflow_err), 64'd0);
        step(1'b1, 64'hDEAD, 6'h01, 1'b1, 1'b0);
        check("ovf_set", 64'(overflow_err), 64'd1);
        check("ovf_occ", 64'(occupancy), 64'd8);
        for (int i = 0; i < DEPTH; i++) begin
            check("drain_order", out_tdata, 64'(i));
            step(1'b0, 64'h0, 6'h0, 1'b0, 1'b1);
        end
        step(1'b0, 64'h0, 6'h0, 1'b0, 1'b1);
        check("drain_credits", 64'(credits_seen), 64'd8);
        check("drain_occ", 64'(occupancy), 64'd0);

        // push and pop together at full
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1'b1, 64'(i + 16), 6'h01, 1'b1, 1'b0);
        step(1'b1, 64'h77, 6'h02, 1'b1, 1'b1);
        check("full_pp_occ", 64'(occupancy), 64'd8);
        check("full_pp_ovf", 64'(overflow_err), 64'd0);
        check("full_pp_credit", 64'(credit_out), 64'd1);
        check("full_pp_head", out_tdata, 64'd17);

        // 20 flits, random ready, wrap-around ordering
        do_reset();
        cyc = 0;
        while (sent.size() < 20 && cyc < 500) begin
            logic s;
            logic [FW-1:0] d;
            s = ($urandom_range(0, 3) != 0) && (q.size() < DEPTH);
            d = {$urandom, $urandom};
            if (s) sent.push_back(d);
            step(s, d, 6'h03, 1'b1, 1'($urandom_range(0, 1)));
            cyc++;
        end
        cyc = 0;
        while (q.size() != 0 && cyc < 50) begin
            step(1'b0, 64'h0, 6'h0, 1'b0, 1'b1);
            cyc++;
        end
        step(1'b0, 64'h0, 6'h0, 1'b0, 1'b0);
        check("wrap_sent", 64'(sent.size()), 64'd20);
        check("wrap_credits", 64'(credits_seen), 64'd20);
        check("wrap_count", 64'(dut_out.size()), 64'd20);
        for (int i = 0; i < 20 && i < dut_out.size(); i++) check("wrap_order", dut_out[i], sent[i]);

        // packet dest change, then clean single-flit packet
        do_reset();
        step(1'b1, 64'h1, 6'h05, 1'b0, 1'b1);
        step(1'b1, 64'h2, 6'h05, 1'b0, 1'b1);
        step(1'b1, 64'h3, 6'h07, 1'b1, 1'b1);
        check("proto_pre", 64'(proto_err), 64'd0);
        step(1'b1, 64'h4, 6'h02, 1'b1, 1'b1);
        check("proto_set", 64'(proto_err), 64'd1);
        repeat (2) step(1'b0, 64'h0, 6'h0, 1'b0, 1'b1);
        check("proto_sticky", 64'(proto_err), 64'd1);

        // legal packets with different dests: FSM must relatch each packet
        do_reset();
        step(1'b1, 64'h1, 6'h05, 1'b0, 1'b1);
        step(1'b1, 64'h2, 6'h05, 1'b1, 1'b1);
        step(1'b1, 64'h3, 6'h09, 1'b1, 1'b1);
        step(1'b1, 64'h4, 6'h04, 1'b0, 1'b1);
        step(1'b1, 64'h5, 6'h04, 1'b1, 1'b1);
        repeat (2) step(1'b0, 64'h0, 6'h0, 1'b0, 1'b1);
        check("proto_clean", 64'(proto_err), 64'd0);

        // reset mid-stream at occupancy 5 with overflow set
        do_reset();
        for (int i = 0; i < DEPTH + 1; i++) step(1'b1, 64'(i), 6'h01, 1'b1, 1'b0);
        repeat (3) step(1'b0, 64'h0, 6'h0, 1'b0, 1'b1);
        out_tready = 1'b0;
        check("mid_occ5", 64'(occupancy), 64'd5);
        #2 rst_n = 1'b0;
        model_clear();
        #1;
        check("mid_tvalid", 64'(out_tvalid), 64'd0);
        check("mid_occ", 64'(occupancy), 64'd0);
        check("mid_credit", 64'(credit_out), 64'd0);
        check("mid_ovf", 64'(overflow_err), 64'd0);
        check("mid_proto", 64'(proto_err), 64'd0);
        @(negedge clk_noc);
        rst_n = 1'b1;
        repeat (3) step(1'b0, 64'h0, 6'h0, 1'b0, 1'b1);

        // long random traffic against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 2) != 0), {$urandom, $urandom},
                 6'($urandom_range(0, 3)), 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 2) != 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
